// File: rtl/alu_sequencer.sv
// alu_sequencer: Moore control sequencer for a single-bus ALU datapath.
// Accepts one instruction per start pulse while idle. It then steps through
// the operand fetch, execute and write-back microsteps and ends with a done
// pulse. An unsupported opcode ends instead with an illegal/done pulse.
module alu_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [4:0]  ops,
  output logic [3:0]  rsel,
  output logic        rout,
  output logic        rin,
  output logic        yin,
  output logic        zin,
  output logic        zlo_out,
  output logic        zhi_out,
  output logic        lo_in,
  output logic        hi_in
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH_A = 3'd1;
  localparam logic [2:0] EXEC    = 3'd2;
  localparam logic [2:0] WB_LO   = 3'd3;
  localparam logic [2:0] WB_HI   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ERR     = 3'd6;

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;

  logic [2:0]  state, state_nxt;
  logic [31:0] ir_q;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       muldiv, unary;

  assign opcode = ir_q[31:27];
  assign ra     = ir_q[26:23];
  assign rb     = ir_q[22:19];
  assign rc     = ir_q[18:15];
  assign muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign unary  = (opcode == OP_NEG) || (opcode == OP_NOT);

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b01111, 5'b10000, 5'b10001, 5'b10010: is_legal = 1'b1;
      default:                                 is_legal = 1'b0;
    endcase
  endfunction

  // State register and instruction latch; the instruction is captured only on accept.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (clear) begin
      state <= IDLE;
      ir_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) ir_q <= ir;
    end
  end

  // Next-state decode; start is only considered while idle.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (!start)                  state_nxt = IDLE;
        else if (is_legal(ir[31:27])) state_nxt = FETCH_A;
        else                          state_nxt = ERR;
      end
      FETCH_A: state_nxt = EXEC;
      EXEC:    state_nxt = WB_LO;
      WB_LO:   state_nxt = muldiv ? WB_HI : DONE;
      WB_HI:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore output decode from the current state and the latched instruction.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    busy    = (state != IDLE);
    done    = 1'b0;
    illegal = 1'b0;
    ops     = 5'b00000;
    rsel    = 4'd0;
    rout    = 1'b0;
    rin     = 1'b0;
    yin     = 1'b0;
    zin     = 1'b0;
    zlo_out = 1'b0;
    zhi_out = 1'b0;
    lo_in   = 1'b0;
    hi_in   = 1'b0;
    case (state)
      FETCH_A: begin
        rout = 1'b1;
        yin  = 1'b1;
        rsel = muldiv ? ra : rb;
      end
      EXEC: begin
        ops  = opcode;
        zin  = 1'b1;
        rsel = muldiv ? rb : rc;
        rout = !unary;
      end
      WB_LO: begin
        zlo_out = 1'b1;
        if (muldiv) begin
          lo_in = 1'b1;
        end else begin
          rsel = ra;
          rin  = 1'b1;
        end
      end
      WB_HI: begin
        zhi_out = 1'b1;
        hi_in   = 1'b1;
      end
      DONE: done = 1'b1;
      ERR: begin
        illegal = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized self-checking bench with a per-instruction
// microstep reference model derived from the instruction semantics.
module tb_alu_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       illegal;
    logic [4:0] ops;
    logic [3:0] rsel;
    logic       rout;
    logic       rin;
    logic       yin;
    logic       zin;
    logic       zlo_out;
    logic       zhi_out;
    logic       lo_in;
    logic       hi_in;
  } obs_t;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] ir    = '0;
  logic        busy, done, illegal, rout, rin, yin, zin, zlo_out, zhi_out, lo_in, hi_in;
  logic [4:0]  ops;
  logic [3:0]  rsel;

  obs_t obs;
  assign obs = {busy, done, illegal, ops, rsel, rout, rin, yin, zin, zlo_out, zhi_out, lo_in, hi_in};

  int total  = 0;
  int passed = 0;
  obs_t exp_q[$];

  alu_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir),
    .busy(busy), .done(done), .illegal(illegal), .ops(ops), .rsel(rsel),
    .rout(rout), .rin(rin), .yin(yin), .zin(zin), .zlo_out(zlo_out),
    .zhi_out(zhi_out), .lo_in(lo_in), .hi_in(hi_in)
  );

  always #5 clock = ~clock;

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: the list of per-cycle outputs following the accept edge.
  task automatic build_expected(input logic [31:0] instr);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       legal, md, un;
    obs_t       v;
    op = instr[31:27];
    ra = instr[26:23];
    rb = instr[22:19];
    rc = instr[18:15];
    legal = op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                       5'd15, 5'd16, 5'd17, 5'd18};
    md = (op == 5'd15) || (op == 5'd16);
    un = (op == 5'd17) || (op == 5'd18);
    exp_q.delete();
    if (!legal) begin
      v = '0; v.busy = 1; v.done = 1; v.illegal = 1; exp_q.push_back(v);
    end else begin
      v = '0; v.busy = 1; v.rout = 1; v.yin = 1; v.rsel = md ? ra : rb; exp_q.push_back(v);
      v = '0; v.busy = 1; v.ops = op; v.zin = 1; v.rout = !un; v.rsel = md ? rb : rc;
      exp_q.push_back(v);
      if (md) begin
        v = '0; v.busy = 1; v.zlo_out = 1; v.lo_in = 1; exp_q.push_back(v);
        v = '0; v.busy = 1; v.zhi_out = 1; v.hi_in = 1; exp_q.push_back(v);
      end else begin
        v = '0; v.busy = 1; v.zlo_out = 1; v.rsel = ra; v.rin = 1; exp_q.push_back(v);
      end
      v = '0; v.busy = 1; v.done = 1; exp_q.push_back(v);
    end
  endtask

  task automatic test_reset();
    clear = 1; start = 1; ir = 32'h19890000;
    tick(); tick();
    total++;
    if (obs !== obs_t'(0)) $display("FAIL reset: got %h expected %h", obs, obs_t'(0));
    else passed++;
    clear = 0; start = 0;
    tick();
    total++;
    if (obs !== obs_t'(0)) $display("FAIL reset_idle: got %h expected %h", obs, obs_t'(0));
    else passed++;
  endtask

  // add R3,R1,R2 with ir scrambled after accept.
  task automatic test_add();
    build_expected(32'h19890000);
    start = 1; ir = 32'h19890000;
    tick();
    start = 0; ir = 32'hFFFF_FFFF;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs !== exp_q[i]) $display("FAIL add cycle %0d: got %h expected %h", i + 1, obs, exp_q[i]);
      else passed++;
      if (i == 1) begin
        total++;
        if (ops !== 5'b00011 || rsel !== 4'd2)
          $display("FAIL add_exec_fields: got ops=%b rsel=%0d expected ops=00011 rsel=2", ops, rsel);
        else passed++;
      end
      if (i < exp_q.size() - 1) tick();
    end
    tick();
    total++;
    if (obs !== obs_t'(0)) $display("FAIL add_idle: got %h expected %h", obs, obs_t'(0));
    else passed++;
  endtask

  // mul R5,R6, plus a start during DONE that must be ignored.
  task automatic test_mul();
    int rin_count;
    build_expected(32'h7AB00000);
    rin_count = 0;
    start = 1; ir = 32'h7AB00000;
    tick();
    start = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs !== exp_q[i]) $display("FAIL mul cycle %0d: got %h expected %h", i + 1, obs, exp_q[i]);
      else passed++;
      rin_count += int'(rin);
      if (i == exp_q.size() - 1) begin
        start = 1; ir = 32'h19890000;
      end
      tick();
    end
    start = 0;
    total++;
    if (obs !== obs_t'(0) || rin_count != 0)
      $display("FAIL mul_done_start_ignored: got %h rin_count=%0d expected %h rin_count=0",
               obs, rin_count, obs_t'(0));
    else passed++;
  endtask

  task automatic test_illegal();
    obs_t v;
    start = 1; ir = 32'hC0000000;
    tick();
    start = 0;
    v = '0; v.busy = 1; v.done = 1; v.illegal = 1;
    total++;
    if (obs !== v) $display("FAIL illegal_pulse: got %h expected %h", obs, v);
    else passed++;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL illegal_busy_cycle2: got %b expected 0", busy);
    else passed++;
  endtask

  // not R4,R7 with a second start during cycle 2; exactly one done, in cycle 4.
  task automatic test_not_busy_start();
    int done_count, done_cycle;
    build_expected(32'h923C0000);
    done_count = 0; done_cycle = 0;
    start = 1; ir = 32'h923C0000;
    tick();
    start = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c <= exp_q.size()) begin
        total++;
        if (obs !== exp_q[c-1]) $display("FAIL not cycle %0d: got %h expected %h", c, obs, exp_q[c-1]);
        else passed++;
      end
      if (done) begin done_count++; done_cycle = c; end
      if (c == 2) begin start = 1; ir = 32'h19890000; end
      else start = 0;
      tick();
    end
    total++;
    if (done_count != 1 || done_cycle != 4)
      $display("FAIL not_single_done: got count=%0d cycle=%0d expected count=1 cycle=4", done_count, done_cycle);
    else passed++;
  endtask

  task automatic test_abort();
    int bad;
    start = 1; ir = 32'h19890000;
    tick();
    start = 0;
    tick();
    total++;
    if (zin !== 1'b1) $display("FAIL abort_in_exec: got zin=%b expected 1", zin);
    else passed++;
    clear = 1;
    tick();
    clear = 0;
    total++;
    if (obs !== obs_t'(0)) $display("FAIL abort_outputs: got %h expected %h", obs, obs_t'(0));
    else passed++;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (obs !== obs_t'(0)) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
    else passed++;
  endtask

  task automatic test_clear_priority();
    int bad;
    clear = 1; start = 1; ir = 32'h19890000;
    tick();
    clear = 0; start = 0;
    total++;
    if (obs !== obs_t'(0)) $display("FAIL clear_priority: got %h expected %h", obs, obs_t'(0));
    else passed++;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (busy !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL clear_priority_busy: got %0d busy cycles expected 0", bad);
    else passed++;
  endtask

  // Random instructions with random start/ir noise while busy.
  task automatic test_random();
    logic [4:0]  legal_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                    5'd11, 5'd15, 5'd16, 5'd17, 5'd18};
    logic [31:0] instr;
    for (int n = 0; n < 60; n++) begin
      instr = $urandom;
      if ($urandom_range(0, 3) != 0) instr[31:27] = legal_ops[$urandom_range(0, 12)];
      build_expected(instr);
      start = 1; ir = instr;
      tick();
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (obs !== exp_q[i])
          $display("FAIL random ir=%h cycle %0d: got %h expected %h", instr, i + 1, obs, exp_q[i]);
        else passed++;
        start = 1'($urandom); ir = $urandom;
        tick();
      end
      start = 0;
      total++;
      if (obs !== obs_t'(0)) $display("FAIL random_idle ir=%h: got %h expected %h", instr, obs, obs_t'(0));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_illegal();
    test_not_busy_start();
    test_abort();
    test_clear_priority();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
